frame_buf_sched: RTL and testbench

- Triple-buffer frame scheduler in the GCK domain of the LED display driver.
- Decides which of three frame slots the data collector writes, which slot the PWM/scan engine displays, and which completed slot waits for the next Vsync.
- Sequences display passes: one pass per frame in 30fps mode, two passes per frame in 60fps mode.
- Sits between the DCK-side write path (with `wr_done` already synchronized to GCK) and the GCK-side PWM engine.

---
 rtl/frame_buf_sched.sv | 161 ++++++++++++++++
 tb/tb_frame_buf_sched.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/frame_buf_sched.sv
// Triple-buffer frame scheduler: rotates writer/ready/display slots and
// sequences one or two display passes per frame on Vsync.
module frame_buf_sched #(
  parameter int CNT_W = 8
) (
  input  logic             GCK,
  input  logic             rst_n,
  input  logic             Vsync,
  input  logic             mode,
  input  logic             wr_done,
  input  logic             disp_done,
  output logic [1:0]       wr_slot,
  output logic [1:0]       rd_slot,
  output logic             rd_valid,
  output logic             rd_pass,
  output logic             frame_start,
  output logic             busy,
  output logic [CNT_W-1:0] drop_cnt,
  output logic [CNT_W-1:0] repeat_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PASS0 = 2'd1,
    PASS1 = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       wr_slot_q, wr_slot_d;
  logic [1:0]       rdy_slot_q, rdy_slot_d;
  logic [1:0]       rd_slot_q, rd_slot_d;
  logic             rdy_valid_q, rdy_valid_d;
  logic             rd_valid_q, rd_valid_d;
  logic             mode_lat_q, mode_lat_d;
  logic             frame_start_q, frame_start_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [CNT_W-1:0] repeat_cnt_q, repeat_cnt_d;
  logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;

  logic accept, take, rpt, miss, pass_done, drop;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] one;
    one = {{(CNT_W-1){1'b0}}, 1'b1};
    return (v == {CNT_W{1'b1}}) ? v : v + one;
  endfunction

  always_comb begin
    accept    = (state_q == IDLE) && Vsync;
    take      = accept && rdy_valid_q;
    rpt       = accept && !rdy_valid_q && rd_valid_q;
    miss      = Vsync && (state_q != IDLE);
    // A done pulse coinciding with frame_start belongs to no pass yet.
    pass_done = disp_done && !frame_start_q;
  end

  // Slot permutation and validity flags.
  always_comb begin
    wr_slot_d   = wr_slot_q;
    rdy_slot_d  = rdy_slot_q;
    rd_slot_d   = rd_slot_q;
    rdy_valid_d = rdy_valid_q;
    rd_valid_d  = rd_valid_q;
    drop        = 1'b0;
    if (take && wr_done) begin
      // Ready frame goes to display, freshly written frame becomes ready.
      rd_slot_d  = rdy_slot_q;
      rdy_slot_d = wr_slot_q;
      wr_slot_d  = rd_slot_q;
    end else if (take) begin
      rd_slot_d   = rdy_slot_q;
      rdy_slot_d  = rd_slot_q;
      rdy_valid_d = 1'b0;
    end else if (wr_done) begin
      wr_slot_d   = rdy_slot_q;
      rdy_slot_d  = wr_slot_q;
      rdy_valid_d = 1'b1;
      drop        = rdy_valid_q;
    end
    if (take) begin
      rd_valid_d = 1'b1;
    end
  end

  always_comb begin
    state_d       = state_q;
    mode_lat_d    = mode_lat_q;
    frame_start_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (take || rpt) begin
          state_d       = PASS0;
          mode_lat_d    = mode;
          frame_start_d = 1'b1;
        end
      end
      PASS0: begin
        if (pass_done) begin
          if (mode_lat_q) begin
            state_d       = PASS1;
            frame_start_d = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      PASS1: begin
        if (pass_done) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    drop_cnt_d   = drop ? sat_inc(drop_cnt_q) : drop_cnt_q;
    repeat_cnt_d = rpt  ? sat_inc(repeat_cnt_q) : repeat_cnt_q;
    miss_cnt_d   = miss ? sat_inc(miss_cnt_q) : miss_cnt_q;
  end

  always_ff @(posedge GCK or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      wr_slot_q     <= 2'd0;
      rdy_slot_q    <= 2'd1;
      rd_slot_q     <= 2'd2;
      rdy_valid_q   <= 1'b0;
      rd_valid_q    <= 1'b0;
      mode_lat_q    <= 1'b0;
      frame_start_q <= 1'b0;
      drop_cnt_q    <= '0;
      repeat_cnt_q  <= '0;
      miss_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      wr_slot_q     <= wr_slot_d;
      rdy_slot_q    <= rdy_slot_d;
      rd_slot_q     <= rd_slot_d;
      rdy_valid_q   <= rdy_valid_d;
      rd_valid_q    <= rd_valid_d;
      mode_lat_q    <= mode_lat_d;
      frame_start_q <= frame_start_d;
      drop_cnt_q    <= drop_cnt_d;
      repeat_cnt_q  <= repeat_cnt_d;
      miss_cnt_q    <= miss_cnt_d;
    end
  end

  assign wr_slot     = wr_slot_q;
  assign rd_slot     = rd_slot_q;
  assign rd_valid    = rd_valid_q;
  assign rd_pass     = (state_q == PASS1);
  assign frame_start = frame_start_q;
  assign busy        = (state_q != IDLE);
  assign drop_cnt    = drop_cnt_q;
  assign repeat_cnt  = repeat_cnt_q;
  assign miss_cnt    = miss_cnt_q;

endmodule

// File: tb/tb_frame_buf_sched.sv
// Directed bench for frame_buf_sched: inputs change on the falling edge,
// outputs are sampled on the falling edge after the capturing rising edge.
module tb_frame_buf_sched;

  logic       GCK = 1'b0;
  logic       rst_n = 1'b0;
  logic       Vsync = 1'b0;
  logic       mode = 1'b0;
  logic       wr_done = 1'b0;
  logic       disp_done = 1'b0;
  logic [1:0] wr_slot, rd_slot;
  logic       rd_valid, rd_pass, frame_start, busy;
  logic [7:0] drop_cnt, repeat_cnt, miss_cnt;

  int tests_run = 0;
  int tests_failed = 0;

  frame_buf_sched #(.CNT_W(8)) dut (
    .GCK(GCK), .rst_n(rst_n), .Vsync(Vsync), .mode(mode),
    .wr_done(wr_done), .disp_done(disp_done),
    .wr_slot(wr_slot), .rd_slot(rd_slot), .rd_valid(rd_valid),
    .rd_pass(rd_pass), .frame_start(frame_start), .busy(busy),
    .drop_cnt(drop_cnt), .repeat_cnt(repeat_cnt), .miss_cnt(miss_cnt)
  );

  always #5 GCK = ~GCK;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // One clock of stimulus; returns on the falling edge after capture.
  task automatic step(input logic wd, input logic vs, input logic dd);
    wr_done = wd; Vsync = vs; disp_done = dd;
    @(negedge GCK);
    wr_done = 1'b0; Vsync = 1'b0; disp_done = 1'b0;
    $display("[TB] t=%0t wr_done=%0b Vsync=%0b disp_done=%0b mode=%0b -> wr=%0d rdy=%0d rd=%0d fs=%0b busy=%0b pass=%0b",
             $time, wd, vs, dd, mode, wr_slot, dut.rdy_slot_q, rd_slot, frame_start, busy, rd_pass);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge GCK);
    @(negedge GCK);
    rst_n = 1'b1;
    @(negedge GCK);
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_wr"}, wr_slot, 0);
    check_eq({tag, "_rdy"}, dut.rdy_slot_q, 1);
    check_eq({tag, "_rd"}, rd_slot, 2);
    check_eq({tag, "_rdv"}, rd_valid, 0);
    check_eq({tag, "_fs"}, frame_start, 0);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_pass"}, rd_pass, 0);
    check_eq({tag, "_cnts"}, {drop_cnt, repeat_cnt, miss_cnt}, 0);
  endtask

  initial begin
    @(negedge GCK);
    do_reset();
    check_reset_vals("reset");

    // 1: single frame, 30fps
    step(1, 0, 0);
    check_eq("t1_wd_wr", wr_slot, 1);
    check_eq("t1_wd_rdy", dut.rdy_slot_q, 0);
    mode = 1'b0;
    step(0, 1, 0);
    check_eq("t1_rd", rd_slot, 0);
    check_eq("t1_wr", wr_slot, 1);
    check_eq("t1_rdv", rd_valid, 1);
    check_eq("t1_fs", frame_start, 1);
    check_eq("t1_busy", busy, 1);
    step(0, 0, 0);
    check_eq("t1_fs_low", frame_start, 0);
    step(0, 0, 1);
    check_eq("t1_idle", busy, 0);

    // 2: 60fps frame; mode toggled and early disp_done ignored mid-frame
    step(1, 0, 0);
    check_eq("t2_wd_wr", wr_slot, 2);
    check_eq("t2_wd_rdy", dut.rdy_slot_q, 1);
    mode = 1'b1;
    step(0, 1, 0);
    check_eq("t2_rd", rd_slot, 1);
    check_eq("t2_fs0", frame_start, 1);
    check_eq("t2_pass0", rd_pass, 0);
    mode = 1'b0;
    step(0, 0, 1);
    check_eq("t2_dd_ignored_busy", busy, 1);
    check_eq("t2_dd_ignored_pass", rd_pass, 0);
    check_eq("t2_fs0_low", frame_start, 0);
    step(0, 0, 1);
    check_eq("t2_fs1", frame_start, 1);
    check_eq("t2_pass1", rd_pass, 1);
    check_eq("t2_busy1", busy, 1);
    step(0, 0, 0);
    check_eq("t2_fs1_low", frame_start, 0);
    step(0, 0, 1);
    check_eq("t2_idle", busy, 0);
    check_eq("t2_pass_clr", rd_pass, 0);

    // 3: two writes before Vsync drop one frame
    do_reset();
    step(1, 0, 0);
    step(1, 0, 0);
    check_eq("t3_drop", drop_cnt, 1);
    check_eq("t3_rdy", dut.rdy_slot_q, 1);
    check_eq("t3_wr", wr_slot, 0);
    step(0, 1, 0);
    check_eq("t3_rd", rd_slot, 1);
    check_eq("t3_fs", frame_start, 1);
    step(0, 0, 0);
    step(0, 0, 1);
    check_eq("t3_idle", busy, 0);

    // 4: repeat with no fresh frame, then Vsync with nothing ever written
    step(0, 1, 0);
    check_eq("t4_repeat", repeat_cnt, 1);
    check_eq("t4_rd", rd_slot, 1);
    check_eq("t4_fs", frame_start, 1);
    step(0, 0, 0);
    step(0, 0, 1);
    do_reset();
    step(0, 1, 0);
    check_eq("t4_empty_fs", frame_start, 0);
    check_eq("t4_empty_busy", busy, 0);
    check_eq("t4_empty_repeat", repeat_cnt, 0);

    // 5: missed Vsyncs during a pass and on the final disp_done
    step(1, 0, 0);
    step(0, 1, 0);
    step(0, 0, 0);
    step(0, 1, 0);
    check_eq("t5_miss1", miss_cnt, 1);
    step(0, 1, 1);
    check_eq("t5_miss2", miss_cnt, 2);
    check_eq("t5_idle", busy, 0);
    check_eq("t5_slots", {rd_slot, dut.rdy_slot_q, wr_slot}, {2'd0, 2'd2, 2'd1});
    check_eq("t5_repeat", repeat_cnt, 0);

    // 6: take and wr_done together, then asynchronous reset mid-pass
    do_reset();
    step(1, 0, 0);
    step(1, 1, 0);
    check_eq("t6_rd", rd_slot, 0);
    check_eq("t6_rdy", dut.rdy_slot_q, 1);
    check_eq("t6_wr", wr_slot, 2);
    check_eq("t6_rdyv", dut.rdy_valid_q, 1);
    check_eq("t6_drop", drop_cnt, 0);
    check_eq("t6_fs", frame_start, 1);
    rst_n = 1'b0;
    #1;
    check_reset_vals("t6_async");
    @(negedge GCK);
    rst_n = 1'b1;
    @(negedge GCK);
    check_eq("t6_post_busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
